// File: rtl/calc_sequencer.sv
// Calculator control sequencer: debounced button entry of two sign-magnitude operands,
// one-hot operator selection, ALU launch over start/done, and display source/mode control.
module calc_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000,
  parameter int unsigned MAX_VAL         = 999999,
  parameter int unsigned ALU_TIMEOUT     = 64
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic [3:0]  buttons,
  input  logic [5:0]  switches,
  input  logic        alu_done,
  input  logic        alu_error,
  input  logic [20:0] alu_result,
  output logic [20:0] num1,
  output logic [20:0] num2,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic [20:0] disp_value,
  output logic [1:0]  disp_mode,
  output logic [9:0]  leds
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [DbW-1:0]  DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] RepMax  = RepW'(REPEAT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ALU_TIMEOUT - 1);
  localparam logic [20:0]     MaxVal  = 21'(MAX_VAL);

  // One-hot encoding so the state register drives the LEDs directly.
  typedef enum logic [5:0] {
    StEnter1   = 6'b000001,
    StEnter2   = 6'b000010,
    StSelect   = 6'b000100,
    StExec     = 6'b001000,
    StShow     = 6'b010000,
    StResetMsg = 6'b100000
  } state_e;

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      pressed_q, pressed_d;  // debounced level, 1 = held
  logic [3:0]      press_evt;
  logic [DbW-1:0]  db_cnt_q [4];
  logic [DbW-1:0]  db_cnt_d [4];
  logic [RepW-1:0] rep_cnt_q [2];
  logic [RepW-1:0] rep_cnt_d [2];
  logic [1:0]      inc_q, inc_d;          // [0] +1, [1] +10
  logic [1:0]      cmd_q, cmd_d;          // [0] store, [1] clear

  state_e          state_q, state_d;
  logic [19:0]     acc_q, acc_d;
  logic [20:0]     num1_q, num1_d, num2_q, num2_d, res_q, res_d;
  logic            err_q, err_d, start_q, start_d, disarm_q, disarm_d;
  logic [2:0]      op_q, op_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic [20:0]     entry_val, acc_sum;
  logic [19:0]     acc_inc;
  logic [2:0]      op_cnt, op_idx;

  // Debounce and auto-repeat next-state; a counter runs only while the synced pin disagrees.
  always_comb begin
    pressed_d = pressed_q;
    press_evt = '0;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if ((~sync2_q[i]) != pressed_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          pressed_d[i] = ~pressed_q[i];
          press_evt[i] = ~pressed_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      rep_cnt_d[i] = (pressed_q[i] && rep_cnt_q[i] != RepMax) ? rep_cnt_q[i] + 1'b1 : '0;
      inc_d[i]     = press_evt[i] | (pressed_q[i] & (rep_cnt_q[i] == RepMax));
    end
    cmd_d = press_evt[3:2];
  end

  // Button synchronizers, debounce counters and registered button events.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      pressed_q <= '0;
      inc_q     <= '0;
      cmd_q     <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= buttons;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      inc_q     <= inc_d;
      cmd_q     <= cmd_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < 2; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end

  // Negative zero collapses to +0; increments saturate at the display ceiling.
  assign entry_val = {switches[5] & (acc_q != '0), acc_q};
  assign acc_sum   = {1'b0, acc_q} + (inc_q[0] ? 21'd1 : 21'd0) + (inc_q[1] ? 21'd10 : 21'd0);
  assign acc_inc   = (acc_sum > MaxVal) ? MaxVal[19:0] : acc_sum[19:0];

  // Operator switch population count and index of the highest set bit.
  always_comb begin
    op_cnt = '0;
    op_idx = '0;
    for (int i = 0; i < 5; i++) begin
      if (switches[i]) begin
        op_cnt = op_cnt + 3'd1;
        op_idx = 3'(i);
      end
    end
  end

  // Sequencer next-state: clear beats store, store beats increments.
  always_comb begin
    state_d  = state_q;
    acc_d    = (inc_q != '0) ? acc_inc : acc_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    res_d    = res_q;
    err_d    = err_q;
    start_d  = 1'b0;
    disarm_d = disarm_q;
    op_d     = op_q;
    tmo_d    = tmo_q;
    if (cmd_q[1] && state_q != StResetMsg) begin
      num1_d  = '0;
      num2_d  = '0;
      acc_d   = '0;
      state_d = StResetMsg;
    end else begin
      unique case (state_q)
        StEnter1: if (cmd_q[0]) begin
          num1_d  = entry_val;
          acc_d   = '0;
          state_d = StEnter2;
        end
        StEnter2: if (cmd_q[0]) begin
          num2_d   = entry_val;
          acc_d    = '0;
          disarm_d = 1'b0;
          state_d  = StSelect;
        end
        StSelect: begin
          if (disarm_q) begin
            if (switches[4:0] == '0) disarm_d = 1'b0;
          end else if (op_cnt == 3'd1) begin
            op_d    = op_idx;
            start_d = 1'b1;
            tmo_d   = '0;
            state_d = StExec;
          end
        end
        StExec: begin
          tmo_d = tmo_q + 1'b1;
          // The launch cycle itself never accepts a done.
          if (!start_q) begin
            if (alu_done) begin
              res_d   = alu_result;
              err_d   = alu_error;
              state_d = StShow;
            end else if (tmo_q == TmoLast) begin
              res_d   = '0;
              err_d   = 1'b1;
              state_d = StShow;
            end
          end
        end
        StShow: if (cmd_q[0]) begin
          disarm_d = 1'b1;
          state_d  = StSelect;
        end
        StResetMsg: if (cmd_q[1]) state_d = StEnter1;
        default: state_d = StEnter1;
      endcase
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      state_q  <= StEnter1;
      acc_q    <= '0;
      num1_q   <= '0;
      num2_q   <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      disarm_q <= 1'b0;
      op_q     <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      res_q    <= res_d;
      err_q    <= err_d;
      start_q  <= start_d;
      disarm_q <= disarm_d;
      op_q     <= op_d;
      tmo_q    <= tmo_d;
    end
  end

  // Output decode: display source and mode follow the current state.
  always_comb begin
    num1       = num1_q;
    num2       = num2_q;
    alu_op     = op_q;
    alu_start  = start_q;
    leds       = {4'b0000, state_q};
    disp_value = '0;
    disp_mode  = 2'd0;
    unique case (state_q)
      StEnter1, StEnter2: disp_value = entry_val;
      StSelect: begin
        disp_value = num2_q;
        disp_mode  = (op_cnt > 3'd1) ? 2'd1 : 2'd0;
      end
      StExec:     disp_value = num2_q;
      StShow: begin
        disp_value = res_q;
        disp_mode  = err_q ? 2'd1 : 2'd0;
      end
      StResetMsg: disp_mode = 2'd2;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: operator table plus directed entry/timing sequences.
// MAX_VAL is lowered so saturation is reachable within a short run.
module tb_calc_sequencer;
  localparam int unsigned Deb  = 4;
  localparam int unsigned Rep  = 16;
  localparam int unsigned MaxV = 120;
  localparam int unsigned Tmo  = 8;

  localparam logic [9:0] LedE1 = 10'h001, LedE2 = 10'h002, LedSel = 10'h004;
  localparam logic [9:0] LedExec = 10'h008, LedShow = 10'h010, LedRst = 10'h020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  buttons = 4'hF;
  logic [5:0]  switches = 6'd0;
  logic        alu_done = 1'b0, alu_error = 1'b0;
  logic [20:0] alu_result = 21'd0;
  logic [20:0] num1, num2, disp_value;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic [1:0]  disp_mode;
  logic [9:0]  leds;

  int checks = 0, failures = 0, start_cnt = 0, sc = 0, k = 0;

  typedef struct {
    logic [4:0]  sw;
    logic        go;
    logic [2:0]  op;
    logic        err;
    logic [20:0] res;
    logic [1:0]  mode;
    logic [20:0] disp;
  } vec_t;
  vec_t vecs [8];

  calc_sequencer #(
    .DEBOUNCE_CYCLES(Deb), .REPEAT_CYCLES(Rep), .MAX_VAL(MaxV), .ALU_TIMEOUT(Tmo)
  ) dut (
    .CLOCK(clk), .reset(rst_n), .buttons(buttons), .switches(switches),
    .alu_done(alu_done), .alu_error(alu_error), .alu_result(alu_result),
    .num1(num1), .num2(num2), .alu_op(alu_op), .alu_start(alu_start),
    .disp_value(disp_value), .disp_mode(disp_mode), .leds(leds)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alu_start === 1'b1) start_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input int b);
    buttons[b] = 1'b0; step(Deb + 6);
    buttons[b] = 1'b1; step(Deb + 6);
  endtask

  task automatic press_n(input int b, input int n);
    repeat (n) press(b);
  endtask

  initial begin
    vecs[0] = '{5'b00011, 1'b0, 3'd0, 1'b0, 21'd0,       2'd1, 21'h100005};
    vecs[1] = '{5'b10001, 1'b0, 3'd0, 1'b0, 21'd0,       2'd1, 21'h100005};
    vecs[2] = '{5'b00000, 1'b0, 3'd0, 1'b0, 21'd0,       2'd0, 21'h100005};
    vecs[3] = '{5'b00010, 1'b1, 3'd1, 1'b0, 21'd17,      2'd0, 21'd17};
    vecs[4] = '{5'b00100, 1'b1, 3'd2, 1'b1, 21'd5,       2'd1, 21'd5};
    vecs[5] = '{5'b01000, 1'b1, 3'd3, 1'b0, 21'h100003,  2'd0, 21'h100003};
    vecs[6] = '{5'b10000, 1'b1, 3'd4, 1'b1, 21'd0,       2'd1, 21'd0};
    vecs[7] = '{5'b00001, 1'b1, 3'd0, 1'b0, 21'd0,       2'd0, 21'd0};

    // Reset values
    #2 rst_n = 1'b0;
    step(2);
    check("rst_leds", leds, LedE1);
    check("rst_num1", num1, 0);
    check("rst_num2", num2, 0);
    check("rst_disp", disp_value, 0);
    check("rst_mode", disp_mode, 0);
    check("rst_op", alu_op, 0);
    check("rst_start", alu_start, 0);
    rst_n = 1'b1;
    step(2);

    // Entry with a glitch on +1
    press_n(0, 3);
    press_n(1, 2);
    buttons[0] = 1'b0; step(2); buttons[0] = 1'b1; step(Deb + 6);
    check("entry_acc", disp_value, 23);
    press(2);
    check("entry_num1", num1, 23);
    check("entry_leds", leds, LedE2);
    check("entry_acc_cleared", disp_value, 0);

    // Clear from ENTER2, then back to ENTER1
    press(3);
    check("clr_leds", leds, LedRst);
    check("clr_mode", disp_mode, 2);
    check("clr_num1", num1, 0);
    press(3);
    check("clr2_leds", leds, LedE1);

    // Operands 12 and -5
    press(1); press_n(0, 2); press(2);
    press_n(0, 5);
    switches[5] = 1'b1; step(1);
    check("neg_entry_disp", disp_value, 21'h100005);
    press(2);
    check("op_num1", num1, 12);
    check("op_num2", num2, 21'h100005);
    check("op_leds_sel", leds, LedSel);
    check("op_sel_disp", disp_value, 21'h100005);

    // Full operation; a done during the launch cycle must be ignored
    sc = start_cnt;
    switches = 6'b100001; step(1);
    check("add_start", alu_start, 1);
    check("add_op", alu_op, 0);
    alu_done = 1'b1; alu_result = 21'd99; step(1);
    alu_done = 1'b0; alu_result = 21'd0;
    check("add_start_once", alu_start, 0);
    check("add_early_done_ignored", leds, LedExec);
    check("add_num2_stable", num2, 21'h100005);
    step(2);
    alu_done = 1'b1; alu_result = 21'd7; step(1);
    alu_done = 1'b0; alu_result = 21'd0;
    check("add_show", leds, LedShow);
    check("add_disp", disp_value, 7);
    check("add_mode", disp_mode, 0);
    check("add_pulses", start_cnt - sc, 1);

    // Back to SELECT with the operator still set: disarmed, no relaunch
    press(2);
    check("disarm_leds", leds, LedSel);
    check("disarm_no_start", start_cnt - sc, 1);

    // Operator table
    for (int i = 0; i < 8; i++) begin
      switches[4:0] = 5'd0; step(2);
      sc = start_cnt;
      switches[4:0] = vecs[i].sw; step(1);
      check($sformatf("vec%0d_start", i), alu_start, vecs[i].go);
      if (vecs[i].go) begin
        check($sformatf("vec%0d_op", i), alu_op, vecs[i].op);
        check($sformatf("vec%0d_num1", i), num1, 12);
        step(1);
        alu_done = 1'b1; alu_error = vecs[i].err; alu_result = vecs[i].res; step(1);
        alu_done = 1'b0; alu_error = 1'b0; alu_result = 21'd0;
        check($sformatf("vec%0d_show", i), leds, LedShow);
        check($sformatf("vec%0d_mode", i), disp_mode, vecs[i].mode);
        check($sformatf("vec%0d_disp", i), disp_value, vecs[i].disp);
        press(2);
        check($sformatf("vec%0d_back", i), leds, LedSel);
      end else begin
        step(3);
        check($sformatf("vec%0d_leds", i), leds, LedSel);
        check($sformatf("vec%0d_mode", i), disp_mode, vecs[i].mode);
        check($sformatf("vec%0d_disp", i), disp_value, vecs[i].disp);
        check($sformatf("vec%0d_nostart", i), start_cnt - sc, 0);
      end
    end

    // ALU never answers: SHOW with error exactly Tmo cycles after the start cycle
    switches[4:0] = 5'd0; step(2);
    switches[4:0] = 5'b01000; step(1);
    check("tmo_start", alu_start, 1);
    step(Tmo - 1);
    check("tmo_still_exec", leds, LedExec);
    step(1);
    check("tmo_show", leds, LedShow);
    check("tmo_mode", disp_mode, 1);
    press(2);

    // Clear during EXEC, then a late done
    switches[4:0] = 5'd0; step(2);
    buttons[3] = 1'b0; switches[4:0] = 5'b00001; step(1);
    check("cx_start", alu_start, 1);
    check("cx_exec", leds, LedExec);
    k = 0;
    while (leds === LedExec && k < 12) begin step(1); k++; end
    check("cx_leds", leds, LedRst);
    alu_done = 1'b1; alu_result = 21'd9; step(1);
    alu_done = 1'b0; alu_result = 21'd0;
    check("cx_late_done", leds, LedRst);
    check("cx_mode", disp_mode, 2);
    check("cx_num1", num1, 0);
    check("cx_num2", num2, 0);
    buttons[3] = 1'b1; step(Deb + 6);
    switches = 6'd0;
    press(3);
    check("cx_second_clear", leds, LedE1);

    // Auto-repeat and saturation
    press_n(1, 11); press_n(0, 5);
    check("sat_preset", disp_value, 115);
    buttons[0] = 1'b0; step(30);
    check("sat_repeat", disp_value, 117);
    step(10 * Rep);
    buttons[0] = 1'b1; step(Deb + 6);
    check("sat_ceiling", disp_value, MaxV);
    press(1);
    check("sat_plus10", disp_value, MaxV);
    press(2);
    check("sat_num1", num1, MaxV);

    // Store and +1 events in the same cycle
    press_n(0, 2);
    buttons[0] = 1'b0; buttons[2] = 1'b0; step(Deb + 6);
    buttons[0] = 1'b1; buttons[2] = 1'b1; step(Deb + 6);
    check("prio_num2", num2, 2);
    check("prio_leds", leds, LedSel);

    // Negative zero stored as +0
    press(3); press(3);
    switches[5] = 1'b1; step(1);
    check("negzero_disp", disp_value, 0);
    press(2);
    check("negzero_num1", num1, 0);
    switches[5] = 1'b0;
    press(0); press(2);
    check("rs_num2", num2, 1);

    // Asynchronous reset in the middle of EXEC
    step(2);
    switches[4:0] = 5'b10000; step(1);
    check("rs_start", alu_start, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_leds", leds, LedE1);
    check("rs_num2_zero", num2, 0);
    check("rs_op", alu_op, 0);
    check("rs_start_low", alu_start, 0);
    check("rs_disp", disp_value, 0);
    check("rs_mode", disp_mode, 0);
    switches = 6'd0;
    step(2);
    rst_n = 1'b1;
    alu_done = 1'b1; alu_result = 21'd5; step(1);
    alu_done = 1'b0; step(1);
    check("rs_late_done_leds", leds, LedE1);
    check("rs_late_done_disp", disp_value, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control sequencer for the six-digit calculator: debounces the active-low push buttons, builds two sign-magnitude operands by incremental entry, takes a one-hot operator from the switches and launches one operation on the arithmetic unit over a start/done handshake. It then holds the result or error for the display driver. It sits between the board I/O (buttons, switches, LEDs) and the arithmetic unit / seven-segment decoder, replacing ad-hoc stage counting with a single clocked FSM.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000 — cycles a synchronized button must stay stable before a press/release is accepted
- REPEAT_CYCLES, 25000000 — auto-repeat interval for held increment buttons
- MAX_VAL, 999999 — operand magnitude ceiling (six display digits)
- ALU_TIMEOUT, 64 — cycles to wait for alu_done before forcing an error

Ports:
- CLOCK  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- buttons  in  4  active-low push buttons: [0] +1, [1] +10, [2] store, [3] clear
- switches  in  6  [4:0] one-hot operator (add, sub, mul, div, exp); [5] sign applied at store
- alu_done  in  1  arithmetic unit finished (1-cycle pulse)
- alu_error  in  1  qualified by alu_done; overflow / divide-by-zero / bad exponent
- alu_result  in  21  sign-magnitude result, bit 20 = sign; qualified by alu_done
- num1, num2  out  21  stored sign-magnitude operands
- alu_op  out  3  operator index 0..4
- alu_start  out  1  one-cycle launch pulse
- disp_value  out  21  sign-magnitude value for the digit decoder
- disp_mode  out  2  0 = number, 1 = "Error", 2 = "rESEt"
- leds  out  10  one-hot state indicator, [9:6] = 0

## Operation
- Each button: 2-flop synchronizer, then a stability counter. A press event fires once when the input stays low for DEBOUNCE_CYCLES. Release is debounced identically.
- Increment: on a +1/+10 press event, the 20-bit accumulator adds 1/10. While the button is held, it adds again every REPEAT_CYCLES. The sum saturates at MAX_VAL; it never wraps.
- Simultaneous events in one cycle: clear > store > increments. When +1 and +10 fire together, +11 is applied.
- States and transitions:
  - ENTER1 (leds[0]): on store, num1 <= {switches[5], acc}, acc <= 0, go to ENTER2.
  - ENTER2 (leds[1]): on store, num2 <= {switches[5], acc}, acc <= 0, go to SELECT.
  - SELECT (leds[2]):
    - Entering from SHOW sets a disarm flag; the FSM first waits for switches[4:0] == 0.
    - Exactly one bit of [4:0] set: alu_op <= index, pulse alu_start, go to EXEC.
    - More than one bit set: disp_mode = 1, stay in SELECT.
    - Zero bits set: disp_mode = 0, show num2, stay in SELECT.
  - EXEC (leds[3]): wait for alu_done.
    - On alu_done: latch alu_result into disp_value, set disp_mode = alu_error, go to SHOW.
    - If ALU_TIMEOUT cycles pass with no done: disp_mode = 1, go to SHOW.
  - SHOW (leds[4]): hold the display. On store, go to SELECT with the same operands.
  - RESET_MSG (leds[5]): disp_mode = 2. On clear, go to ENTER1.
  - Clear from any state other than RESET_MSG: num1, num2 and acc <= 0, go to RESET_MSG.
- disp_value source:
  - ENTER1/ENTER2: {switches[5], acc}.
  - SELECT: num2.
  - SHOW: latched result.
- A negative zero is stored as +0 (sign forced to 0 when the magnitude is 0).

## Timing
- Reset values:
  - state ENTER1, leds = 10'b0000000001
  - num1 = num2 = disp_value = 0, alu_op = 0, alu_start = 0, disp_mode = 0
  - acc = 0, all debounce counters 0, debounced buttons = released
- Press latency: event fires DEBOUNCE_CYCLES + 2 cycles after the pin goes low. acc and disp_value update 1 cycle after the event.
- alu_start is high for exactly 1 cycle, registered, the cycle after a valid one-hot selection is sampled.
- num1, num2 and alu_op are stable from alu_start until the FSM leaves EXEC.
- alu_done is ignored in the alu_start cycle and in every state except EXEC. The timeout counter starts the cycle after alu_start.
- A result is visible on disp_value/disp_mode 1 cycle after alu_done.
- A reset assertion mid-operation (any state, including EXEC) returns all outputs to reset values immediately. A late alu_done after reset is ignored.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 16, ALU_TIMEOUT = 8.
- Entry/debounce:
  - Stimulus: 3 clean +1 presses, 2 +10 presses, a 2-cycle glitch on [0], then store.
  - Required: num1 = 23, the glitch is ignored, leds = ENTER2, acc = 0.
- Repeat and saturate:
  - Stimulus: acc preset via presses to 999995, then hold +1 for 10 repeat periods.
  - Required: acc stops at 999999, no wrap.
- Full operation:
  - Stimulus: num1 = 12, num2 = −5 (switches[5] = 1 at store); switches = 5'b00001 (add). Model returns alu_result = 7 after 3 cycles.
  - Required: one alu_start pulse, alu_op = 0, SHOW with disp_value = 7, disp_mode = 0.
- Errors:
  - Stimulus: two operator switches set together.
  - Required: disp_mode = 1, no alu_start.
  - Stimulus: single operator, model returns alu_error.
  - Required: disp_mode = 1 in SHOW.
  - Stimulus: single operator, model never responds.
  - Required: SHOW with disp_mode = 1 exactly 8 cycles after the start.
- Priority and clear:
  - Stimulus: store and +1 events in the same cycle.
  - Required: the stored value excludes the +1.
  - Stimulus: clear during EXEC, then a late alu_done.
  - Required: RESET_MSG, disp_mode = 2, operands 0, the late done ignored.
  - Stimulus: second clear.
  - Required: ENTER1.
- Async reset: assert reset mid-EXEC → all outputs return to reset values without waiting for a clock edge.
